// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count and programmable almost-full/almost-empty flags.
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags; otherwise they are tied low.
module fifo_param #(
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned DEPTH         = 16,
   parameter int unsigned AFULL_THRESH  = 14,
   parameter int unsigned AEMPTY_THRESH = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         sclr,
   input  logic                         wren,
   input  logic                         rden,
   input  logic [WIDTH-1:0]             din,
   output logic [WIDTH-1:0]             dout,
   output logic                         full,
   output logic                         empty,
   output logic                         almost_full,
   output logic                         almost_empty,
   output logic [$clog2(DEPTH):0]       count,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] C_DEPTH  = (AW+1)'(DEPTH);
   localparam logic [AW:0] C_AFULL  = (AW+1)'(AFULL_THRESH);
   localparam logic [AW:0] C_AEMPTY = (AW+1)'(AEMPTY_THRESH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic [WIDTH-1:0] r_dout;

   logic w_full;
   logic w_empty;
   logic w_wr_acc;
   logic w_rd_acc;

   // Status is decoded from the registered count only, so no request-to-flag path exists.
   assign w_full   = (r_count == C_DEPTH);
   assign w_empty  = (r_count == '0);
   assign w_wr_acc = wren && !w_full  && !sclr;
   assign w_rd_acc = rden && !w_empty && !sclr;

   always_ff @(posedge clk) begin
      if (w_wr_acc && reset) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_dout   <= '0;
      end else if (sclr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_dout   <= '0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd_acc) begin
            r_dout   <= r_mem[r_rd_ptr];
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef FIFO_ERR_FLAGS_EN
   logic r_overflow;
   logic r_underflow;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (sclr) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (wren && w_full) begin
            r_overflow <= 1'b1;
         end
         if (rden && w_empty) begin
            r_underflow <= 1'b1;
         end
      end
   end

   assign overflow  = r_overflow;
   assign underflow = r_underflow;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

   assign dout         = r_dout;
   assign count        = r_count;
   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (r_count >= C_AFULL);
   assign almost_empty = (r_count <= C_AEMPTY);

endmodule
